// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: bus-to-SPI memory controller (read/write, multi-device, sequential-read hold window)
module spi_mem_ctrl #(
  parameter int ADDR_W = 16,
  parameter int NUM_DEV = 2,
  parameter int SPI_ADDR_BYTES = 3,
  parameter bit SEQ_EN = 1'b1,
  parameter int HOLD_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [7:0] bus_data_tx,
  input  logic bus_read,
  input  logic bus_write,
  output logic [7:0] bus_data_rx,
  output logic bus_wait,
  output logic [7:0] spi_data_tx,
  input  logic [7:0] spi_data_rx,
  output logic spi_txn_start,
  input  logic spi_txn_done,
  output logic spi_force_clock,
  output logic [NUM_DEV-1:0] spi_ce_n
);
  localparam int DEV_BITS = $clog2(NUM_DEV);
  localparam int OFF_W = ADDR_W - DEV_BITS;
  localparam int SA_W = SPI_ADDR_BYTES * 8;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, HOLD, DESELECT} state_t;
  state_t state, state_n;
  logic wr, wr_n, start_n, force_n;
  logic [ADDR_W-1:0] addr, addr_n, addr_inc;
  logic [7:0] data, data_n, rx_n, idx, idx_n, cnt, cnt_n;
  logic [NUM_DEV-1:0] ce_n_n;
  logic [SA_W-1:0] off, off_sh;
  logic byte_done, req, hit, timeout;
  logic [DEV_BITS-1:0] dev_in;
  assign off = SA_W'(addr[OFF_W-1:0]);
  assign off_sh = off << {idx, 3'b000};
  assign dev_in = bus_address[ADDR_W-1 -: DEV_BITS];
  assign addr_inc = addr + ADDR_W'(1);
  assign req = bus_read | bus_write;
  // the device-field compare makes an offset wrap a miss even though the address is last+1
  assign hit = bus_read && !bus_write && bus_address == addr_inc && dev_in == addr[ADDR_W-1 -: DEV_BITS];
  assign timeout = cnt + 8'd1 == 8'(HOLD_CYCLES);
  assign byte_done = !spi_txn_start && spi_txn_done;
  assign bus_wait = state != DONE;
  assign spi_data_tx = state == CMD ? (wr ? 8'h02 : 8'h03) :
                       state == ADDR ? off_sh[SA_W-1 -: 8] :
                       (state == DATA && wr) ? data : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr <= 1'b0;
      addr <= '0;
      data <= 8'h00;
      idx <= 8'h00;
      cnt <= 8'h00;
      bus_data_rx <= 8'h00;
      spi_txn_start <= 1'b0;
      spi_force_clock <= 1'b0;
      spi_ce_n <= '1;
    end else begin
      state <= state_n;
      wr <= wr_n;
      addr <= addr_n;
      data <= data_n;
      idx <= idx_n;
      cnt <= cnt_n;
      bus_data_rx <= rx_n;
      spi_txn_start <= start_n;
      spi_force_clock <= force_n;
      spi_ce_n <= ce_n_n;
    end
  end
  always_comb begin
    state_n = state;
    wr_n = wr;
    addr_n = addr;
    data_n = data;
    idx_n = idx;
    cnt_n = cnt;
    rx_n = bus_data_rx;
    start_n = spi_txn_start && spi_txn_done;
    force_n = spi_force_clock;
    ce_n_n = spi_ce_n;
    case (state)
      IDLE: if (req) begin
        wr_n = bus_write;
        addr_n = bus_address;
        data_n = bus_data_tx;
        ce_n_n = ~(NUM_DEV'(1) << dev_in);
        start_n = 1'b1;
        idx_n = 8'h00;
        state_n = CMD;
      end
      CMD: if (byte_done) begin
        start_n = 1'b1;
        idx_n = 8'h00;
        state_n = ADDR;
      end
      ADDR: if (byte_done) begin
        start_n = 1'b1;
        idx_n = idx == 8'(SPI_ADDR_BYTES - 1) ? 8'h00 : idx + 8'd1;
        state_n = idx == 8'(SPI_ADDR_BYTES - 1) ? DATA : ADDR;
      end
      DATA: if (byte_done) begin
        rx_n = wr ? bus_data_rx : spi_data_rx;
        state_n = DONE;
      end
      DONE: begin
        cnt_n = 8'h00;
        state_n = (!wr && SEQ_EN) ? HOLD : DESELECT;
        force_n = wr || !SEQ_EN;
        ce_n_n = (wr || !SEQ_EN) ? '1 : spi_ce_n;
      end
      HOLD: if (hit) begin
        addr_n = bus_address;
        cnt_n = 8'h00;
        start_n = 1'b1;
        state_n = DATA;
      end else if (req || timeout) begin
        cnt_n = 8'h00;
        force_n = 1'b1;
        ce_n_n = '1;
        state_n = DESELECT;
      end else begin
        cnt_n = cnt + 8'd1;
      end
      DESELECT: if (spi_txn_done) begin
        force_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: randomized self-checking bench for a 2-device and a 4-device controller
module tb_spi_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic rd[2], wr[2], bw[2], st[2], fc[2], done[2];
  logic [15:0] addr[2];
  logic [7:0] dtx[2], drx[2], stx[2], srx[2], resp[2];
  logic [1:0] ce0;
  logic [3:0] ce1;
  logic [3:0] ce[2];
  assign ce[0] = {2'b11, ce0};
  assign ce[1] = ce1;
  spi_mem_ctrl u0 (.clk(clk), .rst(rst), .bus_address(addr[0]), .bus_data_tx(dtx[0]),
    .bus_read(rd[0]), .bus_write(wr[0]), .bus_data_rx(drx[0]), .bus_wait(bw[0]),
    .spi_data_tx(stx[0]), .spi_data_rx(srx[0]), .spi_txn_start(st[0]), .spi_txn_done(done[0]),
    .spi_force_clock(fc[0]), .spi_ce_n(ce0));
  spi_mem_ctrl #(.NUM_DEV(4), .SPI_ADDR_BYTES(2), .HOLD_CYCLES(6)) u1 (.clk(clk), .rst(rst),
    .bus_address(addr[1]), .bus_data_tx(dtx[1]), .bus_read(rd[1]), .bus_write(wr[1]),
    .bus_data_rx(drx[1]), .bus_wait(bw[1]), .spi_data_tx(stx[1]), .spi_data_rx(srx[1]),
    .spi_txn_start(st[1]), .spi_txn_done(done[1]), .spi_force_clock(fc[1]), .spi_ce_n(ce1));
  int ncmp = 0;
  int nfail = 0;
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;
  // engine model: logs every byte with the chip selects seen, flags protocol violations
  logic busy[2], st_q[2];
  logic rst_q;
  int lat[2];
  int nb[2] = '{0, 0};
  int perr[2] = '{0, 0};
  logic [7:0] log_b[2][256];
  logic [3:0] log_ce[2][256];
  logic [3:0] ce_q[2];
  logic [7:0] tx_q[2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy[k] <= 1'b0;
        done[k] <= 1'b1;
      end else if (busy[k]) begin
        if (stx[k] !== tx_q[k]) perr[k] <= perr[k] + 1;
        if (lat[k] == 0) begin
          busy[k] <= 1'b0;
          done[k] <= 1'b1;
          srx[k] <= resp[k];
        end else lat[k] <= lat[k] - 1;
      end else if (st[k]) begin
        busy[k] <= 1'b1;
        done[k] <= 1'b0;
        lat[k] <= int'($urandom_range(0, 3));
        tx_q[k] <= stx[k];
        log_b[k][nb[k] % 256] <= stx[k];
        log_ce[k][nb[k] % 256] <= ce[k];
        nb[k] <= nb[k] + 1;
      end
      if (!rst && !rst_q && (busy[k] || st_q[k]) && ce[k] !== ce_q[k]) perr[k] <= perr[k] + 1;
      ce_q[k] <= ce[k];
      st_q[k] <= st[k];
    end
    rst_q <= rst;
  end
  // reference model state per controller
  bit m_held[2];
  logic [15:0] m_prev[2];
  logic [7:0] m_rx[2];
  int m_tdone[2];
  task automatic xfer(input int k, input bit w, input logic [15:0] a, input logic [7:0] d,
                      input int g, input int rv, input string nm);
    int ab = k ? 2 : 3;
    int db = k ? 2 : 1;
    int hc = k ? 6 : 15;
    int off = int'(a) % (1 << (16 - db));
    int dev = int'(a) >> (16 - db);
    logic [3:0] ece = 4'hF ^ (4'(1) << dev);
    logic [7:0] e[$];
    logic [7:0] r;
    bit sq;
    int n0, c;
    repeat (g) @(negedge clk);
    sq = m_held[k] && !w && (tick - m_tdone[k] <= hc) && a == m_prev[k] + 16'd1 &&
         dev == (int'(m_prev[k]) >> (16 - db));
    r = rv < 0 ? 8'($urandom) : 8'(rv);
    resp[k] = r;
    n0 = nb[k];
    rd[k] = !w; wr[k] = w; addr[k] = a; dtx[k] = d;
    c = 0;
    do begin @(negedge clk); c++; end while (bw[k] && c < 300);
    rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 16'($urandom); dtx[k] = 8'($urandom);
    ncmp++;
    if (bw[k] !== 1'b0) begin nfail++; $display("FAIL %s completion: bus_wait stuck at %b", nm, bw[k]); end
    if (!sq) begin
      e.push_back(w ? 8'h02 : 8'h03);
      for (int i = ab - 1; i >= 0; i--) e.push_back(8'((off >> (8 * i)) & 255));
    end
    e.push_back(w ? d : 8'h00);
    ncmp++;
    if (nb[k] - n0 != e.size()) begin
      nfail++;
      $display("FAIL %s byte count: got %0d want %0d (addr %h)", nm, nb[k] - n0, e.size(), a);
    end else foreach (e[i]) begin
      ncmp++;
      if (log_b[k][(n0 + i) % 256] !== e[i] || log_ce[k][(n0 + i) % 256] !== ece) begin
        nfail++;
        $display("FAIL %s byte %0d: got %h ce %b want %h ce %b", nm, i,
                 log_b[k][(n0 + i) % 256], log_ce[k][(n0 + i) % 256], e[i], ece);
      end
    end
    ncmp++;
    if (drx[k] !== (w ? m_rx[k] : r)) begin
      nfail++; $display("FAIL %s read data: got %h want %h", nm, drx[k], w ? m_rx[k] : r);
    end
    ncmp++;
    if (ce[k] !== ece) begin nfail++; $display("FAIL %s ce at done: got %b want %b", nm, ce[k], ece); end
    if (!w) m_rx[k] = r;
    m_held[k] = !w;
    m_prev[k] = a;
    m_tdone[k] = tick;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ncmp += 5;
      if (bw[k] !== 1'b1) begin nfail++; $display("FAIL reset bus_wait[%0d]: got %b want 1", k, bw[k]); end
      if (drx[k] !== 8'h00) begin nfail++; $display("FAIL reset rx[%0d]: got %h want 00", k, drx[k]); end
      if (st[k] !== 1'b0) begin nfail++; $display("FAIL reset start[%0d]: got %b want 0", k, st[k]); end
      if (fc[k] !== 1'b0) begin nfail++; $display("FAIL reset force[%0d]: got %b want 0", k, fc[k]); end
      if (ce[k] !== 4'hF) begin nfail++; $display("FAIL reset ce[%0d]: got %b want 1111", k, ce[k]); end
    end
    rst = 1'b0;
  endtask
  task automatic test_read_basic;
    int n;
    xfer(0, 1'b0, 16'h0123, 8'h00, 1, 8'hA5, "read0123");
    @(negedge clk);
    ncmp++;
    if (bw[0] !== 1'b1) begin nfail++; $display("FAIL wait pulse: got %b want 1 after done", bw[0]); end
    n = (ce[0] != 4'hF) ? 1 : 0;
    while (ce[0] != 4'hF && n < 40) begin @(negedge clk); if (ce[0] != 4'hF) n++; end
    ncmp += 2;
    if (n != 15) begin nfail++; $display("FAIL hold timeout: ce low %0d cycles want 15", n); end
    if (fc[0] !== 1'b1) begin nfail++; $display("FAIL dummy clock: force got %b want 1", fc[0]); end
  endtask
  task automatic test_write;
    xfer(0, 1'b1, 16'h8042, 8'h5A, 1, -1, "write8042");
    @(negedge clk);
    ncmp += 2;
    if (ce[0] !== 4'hF) begin nfail++; $display("FAIL write deselect: ce got %b want 1111", ce[0]); end
    if (fc[0] !== 1'b1) begin nfail++; $display("FAIL write dummy: force got %b want 1", fc[0]); end
  endtask
  task automatic test_seq;
    xfer(0, 1'b0, 16'h0010, 8'h00, 2, -1, "seq0010");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ncmp++;
      if (ce[0] !== 4'hE) begin nfail++; $display("FAIL seq hold ce: got %b want 1110", ce[0]); end
    end
    xfer(0, 1'b0, 16'h0011, 8'h00, 0, -1, "seq0011");
    xfer(0, 1'b0, 16'h0030, 8'h00, 1, -1, "seq0030");
  endtask
  task automatic test_dev_switch;
    xfer(0, 1'b0, 16'h7FFF, 8'h00, 2, -1, "wrap7fff");
    xfer(0, 1'b0, 16'h8000, 8'h00, 1, -1, "wrap8000");
  endtask
  task automatic test_hold_boundary;
    xfer(1, 1'b0, 16'h1000, 8'h00, 2, -1, "hb1000");
    xfer(1, 1'b0, 16'h1001, 8'h00, 6, -1, "hb1001");
    xfer(1, 1'b0, 16'h1002, 8'h00, 7, -1, "hb1002");
  endtask
  task automatic test_dev4;
    xfer(1, 1'b0, 16'hC0FF, 8'h00, 2, -1, "dev4c0ff");
  endtask
  task automatic test_mid_reset;
    int n0 = nb[0];
    int c = 0;
    repeat (20) @(negedge clk);
    rd[0] = 1'b1; addr[0] = 16'h0456;
    while (nb[0] < n0 + 2 && c < 100) begin @(negedge clk); c++; end
    ncmp++;
    if (nb[0] < n0 + 2) begin nfail++; $display("FAIL midreset reach addr: bytes %0d want 2", nb[0] - n0); end
    rst = 1'b1; rd[0] = 1'b0;
    @(negedge clk);
    ncmp += 5;
    if (ce[0] !== 4'hF) begin nfail++; $display("FAIL midreset ce: got %b want 1111", ce[0]); end
    if (st[0] !== 1'b0) begin nfail++; $display("FAIL midreset start: got %b want 0", st[0]); end
    if (bw[0] !== 1'b1) begin nfail++; $display("FAIL midreset wait: got %b want 1", bw[0]); end
    if (fc[0] !== 1'b0) begin nfail++; $display("FAIL midreset force: got %b want 0", fc[0]); end
    if (drx[0] !== 8'h00) begin nfail++; $display("FAIL midreset rx: got %h want 00", drx[0]); end
    rst = 1'b0;
    m_held = '{0, 0};
    m_rx = '{8'h00, 8'h00};
    xfer(0, 1'b0, 16'h0456, 8'h00, 2, -1, "after_reset");
  endtask
  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      int k = int'($urandom_range(0, 1));
      bit w = ($urandom % 4) == 0;
      int g = int'($urandom_range(0, k ? 8 : 17));
      logic [15:0] a = ($urandom % 2) ? m_prev[k] + 16'd1 : 16'($urandom);
      if ($urandom % 8 == 0) a = 16'h3FFF;
      xfer(k, w, a, 8'($urandom), g, -1, "rand");
    end
  endtask
  initial begin
    rd = '{0, 0}; wr = '{0, 0}; addr = '{16'h0, 16'h0}; dtx = '{8'h0, 8'h0};
    resp = '{8'h0, 8'h0};
    m_held = '{0, 0}; m_prev = '{16'h0, 16'h0}; m_rx = '{8'h0, 8'h0}; m_tdone = '{0, 0};
    test_reset;
    test_read_basic;
    test_write;
    test_seq;
    test_dev_switch;
    test_hold_boundary;
    test_dev4;
    test_mid_reset;
    test_random;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ncmp++;
      if (perr[k] != 0) begin nfail++; $display("FAIL protocol[%0d]: %0d violations want 0", k, perr[k]); end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
